pwm_update_scheduler: RTL

Configures a bank of `pwm_generator` channels by converting per-channel duty/phase requests into RISE/FALL edge pairs and committing them glitch-free at the PWM period boundary. One shared edge-calculation datapath is time-multiplexed across all channels. Results are staged in shadow registers. All channels switch together on the last count of a period, so every generator sees a complete, consistent period.

---
 rtl/pwm_update_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pwm_update_scheduler.sv
// rtl/pwm_update_scheduler.sv - converts per-channel duty/phase into PWM edge pairs
// and commits all channels together on the last count of a PWM period.
module pwm_update_scheduler #(
   parameter int WIDTH = 13,
   parameter int CYCLE = 4096,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [WIDTH-1:0]         TIME_CNT,
   input  logic                     UPDATE,
   input  logic [DEPTH*WIDTH-1:0]   DUTY,
   input  logic [DEPTH*WIDTH-1:0]   PHASE,
   output logic [DEPTH*WIDTH-1:0]   RISE,
   output logic [DEPTH*WIDTH-1:0]   FALL,
   output logic                     BUSY,
   output logic                     COMMIT
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam logic [WIDTH-1:0]        CYC_U    = WIDTH'(CYCLE);
   localparam logic [WIDTH-1:0]        CNT_LAST = WIDTH'(CYCLE - 1);
   localparam logic signed [WIDTH:0]   CYC_S    = (WIDTH+1)'(CYCLE);
   localparam logic [DEPTH-1:0]        IDX_LAST = DEPTH'(DEPTH - 1);

   logic [1:0]               state;
   logic [DEPTH-1:0]         idx;
   logic [DEPTH*WIDTH-1:0]   cap_duty;
   logic [DEPTH*WIDTH-1:0]   cap_phase;
   logic [DEPTH*WIDTH-1:0]   shadow_rise;
   logic [DEPTH*WIDTH-1:0]   shadow_fall;

   logic [WIDTH-1:0]         duty_sel;
   logic [WIDTH-1:0]         phase_sel;
   logic [WIDTH-1:0]         d_clamp;
   logic [WIDTH-1:0]         p_wrap;
   logic [WIDTH-1:0]         d_half;
   logic [WIDTH-1:0]         d_rest;
   logic signed [WIDTH:0]    rise_raw;
   logic signed [WIDTH:0]    fall_raw;
   logic signed [WIDTH:0]    rise_w;
   logic signed [WIDTH:0]    fall_w;
   logic [WIDTH-1:0]         rise_calc;
   logic [WIDTH-1:0]         fall_calc;

   // Shared edge datapath: only the channel addressed by idx is evaluated each cycle.
   always_comb begin
      duty_sel  = '0;
      phase_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx == DEPTH'(i)) begin
            duty_sel  = cap_duty[i*WIDTH +: WIDTH];
            phase_sel = cap_phase[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      d_clamp  = (duty_sel > CYC_U) ? CYC_U : duty_sel;
      p_wrap   = (phase_sel >= CYC_U) ? (phase_sel - CYC_U) : phase_sel;
      d_half   = d_clamp >> 1;
      d_rest   = d_clamp - d_half;
      rise_raw = $signed({1'b0, p_wrap}) - $signed({1'b0, d_half});
      fall_raw = $signed({1'b0, p_wrap}) + $signed({1'b0, d_rest});
      rise_w   = (rise_raw < 0) ? (rise_raw + CYC_S) : rise_raw;
      fall_w   = (fall_raw >= CYC_S) ? (fall_raw - CYC_S) : fall_raw;
      if (d_clamp == CYC_U) begin
         rise_calc = '0;
         fall_calc = CYC_U;
      end else begin
         rise_calc = WIDTH'(rise_w);
         fall_calc = WIDTH'(fall_w);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         idx         <= '0;
         cap_duty    <= '0;
         cap_phase   <= '0;
         shadow_rise <= '0;
         shadow_fall <= '0;
         RISE        <= '0;
         FALL        <= '0;
         COMMIT      <= 1'b0;
      end else begin
         COMMIT <= 1'b0;
         case (state)
            S_IDLE: begin
               if (UPDATE) begin
                  cap_duty  <= DUTY;
                  cap_phase <= PHASE;
                  idx       <= '0;
                  state     <= S_CALC;
               end
            end
            S_CALC: begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (idx == DEPTH'(i)) begin
                     shadow_rise[i*WIDTH +: WIDTH] <= rise_calc;
                     shadow_fall[i*WIDTH +: WIDTH] <= fall_calc;
                  end
               end
               if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= S_WAIT;
               end else begin
                  idx <= idx + DEPTH'(1);
               end
            end
            S_WAIT: begin
               // Swap on the last count so generators see the new edges from count 0.
               if (TIME_CNT == CNT_LAST) begin
                  RISE   <= shadow_rise;
                  FALL   <= shadow_fall;
                  COMMIT <= 1'b1;
                  state  <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   assign BUSY = (state != S_IDLE);

endmodule
